// File: rtl/alu_control_mc_pkg.sv
// Shared definitions for the RV32IM ALU control block.
//   - alu_op_class_e : instruction class driven by the main control unit
//   - mc_state_e     : multi-cycle sequencer state encoding
//   - OPC_*          : 5-bit base operation codes (zero-extended to OP_W by users)
//   - F7_*           : funct7 encodings that select the R-type sub-tables
//   - base_op()      : funct3 -> operation for the plain (funct7 = 0) integer ops
// These codes are shared with the ALU and MDU, so changing them is an
// interface change for both.
package alu_control_mc_pkg;

  typedef enum logic [2:0] {
    CLS_R      = 3'b000,
    CLS_I_ALU  = 3'b001,
    CLS_LUI    = 3'b010,
    CLS_STORE  = 3'b011,
    CLS_LOAD   = 3'b100,
    CLS_BRANCH = 3'b101,
    CLS_JAL    = 3'b110,
    CLS_JALR   = 3'b111
  } alu_op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mc_state_e;

  localparam int BASE_OP_W = 5;
  typedef logic [BASE_OP_W-1:0] op_code_t;

  // Single-cycle ALU operations (legacy 4-bit codes, zero-extended).
  localparam op_code_t OPC_ADD    = 5'b00000;
  localparam op_code_t OPC_SUB    = 5'b00001;
  localparam op_code_t OPC_LW     = 5'b00011;
  localparam op_code_t OPC_AND    = 5'b00100;
  localparam op_code_t OPC_OR     = 5'b00101;
  localparam op_code_t OPC_XOR    = 5'b00110;
  localparam op_code_t OPC_LUI    = 5'b00111;
  localparam op_code_t OPC_SLL    = 5'b01000;
  localparam op_code_t OPC_SRL    = 5'b01010;
  localparam op_code_t OPC_SRA    = 5'b01011;
  localparam op_code_t OPC_SLT    = 5'b01100;
  localparam op_code_t OPC_SLTU   = 5'b01101;

  // M-extension operations: {2'b10, funct3}. Bit 2 separates MUL* from DIV*/REM*.
  localparam op_code_t OPC_MUL    = 5'b10000;
  localparam op_code_t OPC_MULH   = 5'b10001;
  localparam op_code_t OPC_MULHSU = 5'b10010;
  localparam op_code_t OPC_MULHU  = 5'b10011;
  localparam op_code_t OPC_DIV    = 5'b10100;
  localparam op_code_t OPC_DIVU   = 5'b10101;
  localparam op_code_t OPC_REM    = 5'b10110;
  localparam op_code_t OPC_REMU   = 5'b10111;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  // funct3 -> operation for the funct7 = 0x00 R-type table; the I-ALU table
  // is identical apart from the SRL/SRA split, which the caller handles.
  function automatic op_code_t base_op(input logic [2:0] f3);
    op_code_t code;
    case (f3)
      3'b000:  code = OPC_ADD;
      3'b001:  code = OPC_SLL;
      3'b010:  code = OPC_SLT;
      3'b011:  code = OPC_SLTU;
      3'b100:  code = OPC_XOR;
      3'b101:  code = OPC_SRL;
      3'b110:  code = OPC_OR;
      default: code = OPC_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_control_mc_decode.sv
// Purely combinational decoder: {funct7, ALU_Op, funct3} -> operation code.
// Ports:
//   funct7_i  in  7     instr[31:25]
//   alu_op_i  in  3     instruction class from main control
//   funct3_i  in  3     instr[14:12]
//   code_o    out OP_W  operation code (ADD for illegal encodings)
//   is_mc_o   out 1     operation needs the multi-cycle MDU
//   illegal_o out 1     encoding is not supported
module alu_control_mc_decode
  import alu_control_mc_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      alu_op_i,
  input  logic [2:0]      funct3_i,
  output logic [OP_W-1:0] code_o,
  output logic            is_mc_o,
  output logic            illegal_o
);

  alu_op_class_e op_class;
  op_code_t      code;
  logic          is_mc;
  logic          illegal;

  // All eight 3-bit values are named classes, so this cast never yields an
  // out-of-range enum.
  assign op_class = alu_op_class_e'(alu_op_i);

  always_comb begin
    code    = OPC_ADD;
    is_mc   = 1'b0;
    illegal = 1'b0;
    case (op_class)
      CLS_R: begin
        case (funct7_i)
          F7_BASE: code = base_op(funct3_i);
          F7_ALT: begin
            if (funct3_i == 3'b000) begin
              code = OPC_SUB;
            end else if (funct3_i == 3'b101) begin
              code = OPC_SRA;
            end else begin
              illegal = 1'b1;
            end
          end
          F7_MULDIV: begin
            code  = {2'b10, funct3_i};
            is_mc = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      CLS_I_ALU: begin
        // Only the shifts carry meaning in funct7; for the other I-ALU ops
        // those bits are immediate data and must be ignored.
        if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
          if (funct7_i != F7_BASE && funct7_i != F7_ALT) begin
            illegal = 1'b1;
          end else if (funct3_i == 3'b101 && funct7_i[5]) begin
            code = OPC_SRA;
          end else begin
            code = base_op(funct3_i);
          end
        end else begin
          code = base_op(funct3_i);
        end
      end
      CLS_LUI:    code = OPC_LUI;
      CLS_LOAD:   code = OPC_LW;
      CLS_BRANCH: code = OPC_SUB;
      default:    code = OPC_ADD;  // STORE, JAL, JALR: address adder
    endcase
  end

  assign code_o    = OP_W'(code);
  assign is_mc_o   = is_mc;
  assign illegal_o = illegal;

endmodule

// File: rtl/alu_control_mc.sv
// Registered, multi-cycle ALU control for the RV32IM datapath.
// Single-cycle ops report one cycle after valid_i; M-extension ops start the
// MDU and hold stall_o high for exactly LAT cycles, reporting on the last one.
// Parameters: OP_W (>=5), MUL_LAT (>=2), DIV_LAT (>=2).
// Ports:
//   clk              in   1     rising-edge clock
//   reset            in   1     asynchronous active-high reset
//   valid_i          in   1     decode presents a valid instruction
//   flush_i          in   1     abort current/pending operation
//   funct7_i         in   7     instr[31:25]
//   ALU_Op_i         in   3     instruction class from main control
//   funct3_i         in   3     instr[14:12]
//   ALU_Operation_o  out  OP_W  registered operation code
//   op_valid_o       out  1     one-cycle pulse per completed op
//   mc_start_o       out  1     one-cycle MDU start pulse
//   stall_o          out  1     front-end hold, high while not IDLE
//   illegal_o        out  1     pulses with op_valid_o for unsupported encodings
module alu_control_mc
  import alu_control_mc_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      ALU_Op_i,
  input  logic [2:0]      funct3_i,
  output logic [OP_W-1:0] ALU_Operation_o,
  output logic            op_valid_o,
  output logic            mc_start_o,
  output logic            stall_o,
  output logic            illegal_o
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT);

  // BUSY lasts LOAD+1 cycles and DONE one more, so the op reports on the
  // LAT-th stalled cycle counted from the mc_start_o cycle.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

  logic [OP_W-1:0]  dec_code;
  logic             dec_is_mc;
  logic             dec_illegal;

  mc_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [OP_W-1:0]  code_reg, code_next;
  logic             single_valid_reg, single_valid_next;
  logic             mc_start_reg, mc_start_next;
  logic             illegal_reg, illegal_next;

  alu_control_mc_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .funct7_i  (funct7_i),
    .alu_op_i  (ALU_Op_i),
    .funct3_i  (funct3_i),
    .code_o    (dec_code),
    .is_mc_o   (dec_is_mc),
    .illegal_o (dec_illegal)
  );

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      code_reg         <= '0;
      single_valid_reg <= 1'b0;
      mc_start_reg     <= 1'b0;
      illegal_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      code_reg         <= code_next;
      single_valid_reg <= single_valid_next;
      mc_start_reg     <= mc_start_next;
      illegal_reg      <= illegal_next;
    end
  end

  // Next-state logic. New ops are accepted only in IDLE; the code register
  // moves only on acceptance so the datapath sees a stable code otherwise.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    code_next         = code_reg;
    single_valid_next = 1'b0;
    mc_start_next     = 1'b0;
    illegal_next      = 1'b0;
    if (flush_i) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (valid_i) begin
            code_next = dec_code;
            if (dec_is_mc) begin
              state_next    = ST_BUSY;
              mc_start_next = 1'b1;
              // Bit 2 of an M code distinguishes DIV*/REM* from MUL*.
              cnt_next      = dec_code[2] ? DIV_LOAD : MUL_LOAD;
            end else begin
              single_valid_next = 1'b1;
              illegal_next      = dec_illegal;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_reg == '0) begin
            state_next = ST_DONE;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs derived from the registered state.
  always_comb begin
    stall_o    = (state_reg != ST_IDLE);
    op_valid_o = single_valid_reg | (state_reg == ST_DONE);
  end

  assign ALU_Operation_o = code_reg;
  assign mc_start_o      = mc_start_reg;
  assign illegal_o       = illegal_reg;

endmodule
